lieat_ifu_ifetch_ctrl: RTL and testbench

Instruction-fetch sequencer between the PC generator and instruction memory, feeding the ifetch response/decode stage. It issues fetch requests, holds up to `OUTS` in-flight fetches in an in-order slot buffer that tags each with its PC and BPU index, and presents completed fetches downstream as a valid/ready stream. On a redirect (`flush`) it drops every queued and in-flight fetch, including memory responses that arrive after the flush.

---
 rtl/lieat_ifu_ifetch_ctrl.sv | 155 +++++++++++++++
 tb/tb_lieat_ifu_ifetch_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lieat_ifu_ifetch_ctrl.sv
// Instruction-fetch sequencer: issues PCs to imem, tracks in-flight fetches in an in-order slot buffer, streams completed fetches out.
// Latency: PC accept -> rsp_o_valid is 2 cycles with 1-cycle memory; response -> rsp_o_valid is 1 cycle (no bypass).
// Backpressure: rsp_o_ready low holds slots; once occupancy plus pending drops reaches OUTS, pc_ready/mem_req_valid drop.
module lieat_ifu_ifetch_ctrl #(
  parameter int XLEN    = 32,
  parameter int BPU_IDX = 5,
  parameter int OUTS    = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               pc_valid,
  output logic               pc_ready,
  input  logic [XLEN-1:0]    pc_addr,
  input  logic [BPU_IDX-1:0] pc_index,
  input  logic               flush,
  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic [XLEN-1:0]    mem_req_addr,
  input  logic               mem_rsp_valid,
  input  logic [XLEN-1:0]    mem_rsp_data,
  output logic               rsp_o_valid,
  input  logic               rsp_o_ready,
  output logic [XLEN-1:0]    rsp_o_pc,
  output logic [BPU_IDX-1:0] rsp_o_index,
  output logic [XLEN-1:0]    rsp_o_inst
);

  localparam int AW = $clog2(OUTS);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW:0]   OUTS_W  = (PW + 1)'(OUTS);

  // Pointers carry a wrap bit so full (occ == OUTS) and empty (occ == 0) are distinct.
  logic [PW-1:0] wp_q, wp_d;
  logic [PW-1:0] fp_q, fp_d;
  logic [PW-1:0] rp_q, rp_d;
  logic [PW-1:0] drop_q, drop_d;

  logic [XLEN-1:0]    pc_q   [OUTS];
  logic [XLEN-1:0]    pc_d   [OUTS];
  logic [BPU_IDX-1:0] idx_q  [OUTS];
  logic [BPU_IDX-1:0] idx_d  [OUTS];
  logic [XLEN-1:0]    inst_q [OUTS];
  logic [XLEN-1:0]    inst_d [OUTS];
  logic [OUTS-1:0]    filled_q, filled_d;

  logic [AW-1:0] wp_slot, fp_slot, rp_slot;
  logic [PW-1:0] occ;
  logic [PW-1:0] pending;
  logic          can_issue;
  logic          accept;
  logic          pop;

  assign wp_slot = wp_q[AW-1:0];
  assign fp_slot = fp_q[AW-1:0];
  assign rp_slot = rp_q[AW-1:0];
  assign occ     = wp_q - rp_q;

  // Responses still owed by memory that will be discarded if a flush happens now:
  // existing drops plus every issued-but-unfilled slot.
  assign pending = drop_q + (wp_q - fp_q);

  // Slots and drop credits share the OUTS budget so a flush can never let
  // more requests be in flight than memory responses we can account for.
  assign can_issue = (({1'b0, occ} + {1'b0, drop_q}) < OUTS_W);

  // Issue handshake is purely combinational; the PC goes straight to memory.
  assign mem_req_valid = pc_valid & can_issue & ~flush;
  assign pc_ready      = mem_req_ready & can_issue & ~flush;
  assign mem_req_addr  = pc_addr;

  assign rsp_o_valid = filled_q[rp_slot] & (occ != '0) & ~flush;
  assign rsp_o_pc    = pc_q[rp_slot];
  assign rsp_o_index = idx_q[rp_slot];
  assign rsp_o_inst  = inst_q[rp_slot];

  assign accept = pc_valid & pc_ready;
  assign pop    = rsp_o_valid & rsp_o_ready;

  // Next-state for pointers, drop counter and slot contents.
  always_comb begin
    wp_d     = wp_q;
    fp_d     = fp_q;
    rp_d     = rp_q;
    drop_d   = drop_q;
    filled_d = filled_q;
    pc_d     = pc_q;
    idx_d    = idx_q;
    inst_d   = inst_q;

    if (flush) begin
      // Collapse the buffer onto rp; everything unfilled becomes a drop credit,
      // and a response landing this same cycle consumes one of them.
      wp_d     = rp_q;
      fp_d     = rp_q;
      filled_d = '0;
      if (mem_rsp_valid && (pending != '0)) begin
        drop_d = pending - PTR_ONE;
      end else begin
        drop_d = pending;
      end
    end else begin
      if (accept) begin
        pc_d[wp_slot]     = pc_addr;
        idx_d[wp_slot]    = pc_index;
        filled_d[wp_slot] = 1'b0;
        wp_d              = wp_q + PTR_ONE;
      end

      if (mem_rsp_valid) begin
        if (drop_q != '0) begin
          drop_d = drop_q - PTR_ONE;
        end else if (fp_q != wp_q) begin
          inst_d[fp_slot]   = mem_rsp_data;
          filled_d[fp_slot] = 1'b1;
          fp_d              = fp_q + PTR_ONE;
        end
        // A response with nothing outstanding is a memory protocol error and is ignored.
      end

      if (pop) begin
        filled_d[rp_slot] = 1'b0;
        rp_d              = rp_q + PTR_ONE;
      end
    end
  end

  // State registers; reset abandons all fetches and clears every slot field.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wp_q     <= '0;
      fp_q     <= '0;
      rp_q     <= '0;
      drop_q   <= '0;
      filled_q <= '0;
      for (int i = 0; i < OUTS; i++) begin
        pc_q[i]   <= '0;
        idx_q[i]  <= '0;
        inst_q[i] <= '0;
      end
    end else begin
      wp_q     <= wp_d;
      fp_q     <= fp_d;
      rp_q     <= rp_d;
      drop_q   <= drop_d;
      filled_q <= filled_d;
      for (int i = 0; i < OUTS; i++) begin
        pc_q[i]   <= pc_d[i];
        idx_q[i]  <= idx_d[i];
        inst_q[i] <= inst_d[i];
      end
    end
  end

endmodule

// File: tb/tb_lieat_ifu_ifetch_ctrl.sv
// Bench for lieat_ifu_ifetch_ctrl: reset-state vector table, then hand-written fetch sequences.
// Latency: memory model answers one cycle after a request (can be held off with mem_hold).
// Backpressure: rsp_o_ready driven per sequence; a scoreboard checks every delivered fetch.
module tb_lieat_ifu_ifetch_ctrl;

  localparam int XLEN    = 32;
  localparam int BPU_IDX = 5;
  // Four slots: with 1-cycle memory two entries are live every cycle, so this sustains 1 fetch/cycle.
  localparam int OUTS    = 4;

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic               pc_valid = 1'b0;
  logic               pc_ready;
  logic [XLEN-1:0]    pc_addr = '0;
  logic [BPU_IDX-1:0] pc_index = '0;
  logic               flush = 1'b0;
  logic               mem_req_valid;
  logic               mem_req_ready = 1'b0;
  logic [XLEN-1:0]    mem_req_addr;
  logic               mem_rsp_valid = 1'b0;
  logic [XLEN-1:0]    mem_rsp_data = '0;
  logic               rsp_o_valid;
  logic               rsp_o_ready = 1'b0;
  logic [XLEN-1:0]    rsp_o_pc;
  logic [BPU_IDX-1:0] rsp_o_index;
  logic [XLEN-1:0]    rsp_o_inst;

  lieat_ifu_ifetch_ctrl #(.XLEN(XLEN), .BPU_IDX(BPU_IDX), .OUTS(OUTS)) dut (
    .clock(clock), .reset(reset),
    .pc_valid(pc_valid), .pc_ready(pc_ready), .pc_addr(pc_addr), .pc_index(pc_index),
    .flush(flush),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .rsp_o_valid(rsp_o_valid), .rsp_o_ready(rsp_o_ready),
    .rsp_o_pc(rsp_o_pc), .rsp_o_index(rsp_o_index), .rsp_o_inst(rsp_o_inst)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int passes = 0;
  int out_cnt = 0;
  logic mem_hold = 1'b0;

  typedef struct {
    logic [XLEN-1:0]    pc;
    logic [BPU_IDX-1:0] idx;
    logic [XLEN-1:0]    inst;
  } exp_t;

  exp_t            sb[$];
  logic [XLEN-1:0] mem_q[$];

  typedef struct {
    logic            pv;
    logic            mrr;
    logic            fl;
    logic [XLEN-1:0] addr;
    logic            exp_mrv;
    logic            exp_prdy;
  } vec_t;

  vec_t vecs[7];

  function automatic logic [XLEN-1:0] inst_of(input logic [XLEN-1:0] a);
    if (a == 32'h8000_0000) return 32'h0000_0013;
    return (a ^ 32'h1357_9BDF) + 32'h3;
  endfunction

  function automatic logic [BPU_IDX-1:0] idx_of(input logic [XLEN-1:0] a);
    return a[6:2] ^ 5'd3;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_pc(input logic [XLEN-1:0] a);
    pc_addr  = a;
    pc_index = idx_of(a);
    pc_valid = 1'b1;
  endtask

  task automatic drain();
    int n;
    pc_valid = 1'b0;
    n = 0;
    while ((sb.size() != 0 || mem_q.size() != 0) && n < 40) begin
      step();
      n++;
    end
    check("drain_done", {sb.size() == 0, mem_q.size() == 0}, 2'b11);
  endtask

  // Memory model: answers queued requests in order, one per cycle, unless held.
  always @(posedge clock) begin
    #2;
    if (!reset) begin
      mem_rsp_valid = 1'b0;
      mem_q.delete();
    end else if (!mem_hold && mem_q.size() != 0) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = inst_of(mem_q.pop_front());
    end else begin
      mem_rsp_valid = 1'b0;
    end
  end

  // Monitor: sampled mid-cycle, when inputs and outputs are settled for the coming edge.
  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      sb.delete();
      mem_q.delete();
    end else begin
      if (mem_rsp_valid)
        check("rsp_has_slot", (dut.drop_q != 0) || (dut.fp_q != dut.wp_q), 1);
      if (flush)
        check("no_out_in_flush", rsp_o_valid, 0);
      if (rsp_o_valid && rsp_o_ready) begin
        out_cnt++;
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL unexpected_out: got pc 0x%0h, expected no output", rsp_o_pc);
        end else begin
          e = sb.pop_front();
          check("out_pc", rsp_o_pc, e.pc);
          check("out_idx", rsp_o_index, e.idx);
          check("out_inst", rsp_o_inst, e.inst);
        end
      end
      if (flush) sb.delete();
      if (pc_valid && pc_ready) begin
        check("req_valid_on_accept", {mem_req_valid, mem_req_addr}, {1'b1, pc_addr});
        mem_q.push_back(pc_addr);
        sb.push_back('{pc: pc_addr, idx: pc_index, inst: inst_of(pc_addr)});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int s;
    int acc;

    // Combinational issue gating while held in reset (can_issue is 1, buffer empty).
    vecs[0] = '{1'b0, 1'b0, 1'b0, 32'h0000_1000, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 32'h0000_2004, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h0000_3008, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 32'hDEAD_BEE0, 1'b1, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 32'h0000_4010, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 32'h0000_5014, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 32'h0000_6018, 1'b0, 1'b0};

    #2;
    check("rst_rsp_valid", rsp_o_valid, 0);
    check("rst_rsp_fields", {rsp_o_pc, rsp_o_index, rsp_o_inst}, 0);
    check("rst_ptrs", {dut.wp_q, dut.fp_q, dut.rp_q, dut.drop_q}, 0);
    for (int i = 0; i < 7; i++) begin
      pc_valid      = vecs[i].pv;
      mem_req_ready = vecs[i].mrr;
      flush         = vecs[i].fl;
      pc_addr       = vecs[i].addr;
      rsp_o_ready   = 1'b1;
      #1;
      check($sformatf("vec%0d_mem_req_valid", i), mem_req_valid, vecs[i].exp_mrv);
      check($sformatf("vec%0d_pc_ready", i), pc_ready, vecs[i].exp_prdy);
      check($sformatf("vec%0d_req_addr", i), mem_req_addr, vecs[i].addr);
      check($sformatf("vec%0d_rsp_valid", i), rsp_o_valid, 0);
    end
    pc_valid = 1'b0;
    flush    = 1'b0;
    step();
    reset = 1'b1;

    // Single fetch: accept, response next cycle, output the cycle after.
    mem_req_ready = 1'b1;
    rsp_o_ready   = 1'b1;
    drive_pc(32'h8000_0000);
    @(negedge clock);
    check("single_pc_ready", pc_ready, 1);
    step();
    pc_valid = 1'b0;
    @(negedge clock);
    check("single_no_bypass", {mem_rsp_valid, rsp_o_valid}, 2'b10);
    step();
    @(negedge clock);
    check("single_valid", rsp_o_valid, 1);
    check("single_pc", rsp_o_pc, 32'h8000_0000);
    check("single_idx", rsp_o_index, 3);
    check("single_inst", rsp_o_inst, 32'h0000_0013);
    drain();

    // Streaming: 8 back-to-back PCs, one output per cycle after the first.
    s = out_cnt;
    for (int i = 0; i < 8; i++) begin
      drive_pc(32'(4 * i));
      @(negedge clock);
      check($sformatf("stream_pc_ready%0d", i), pc_ready, 1);
      step();
    end
    pc_valid = 1'b0;
    check("stream_outs_mid", out_cnt - s, 6);
    step();
    step();
    check("stream_outs_all", out_cnt - s, 8);
    drain();

    // Backpressure: slots fill, issue stalls, release drains oldest-first.
    rsp_o_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      drive_pc(32'(4 * acc));
      @(negedge clock);
      if (pc_ready) acc++;
      step();
    end
    check("bp_accepts", acc, OUTS);
    rsp_o_ready = 1'b1;
    @(negedge clock);
    check("bp_full_stall", pc_ready, 0);
    check("bp_first_out", {rsp_o_valid, rsp_o_pc}, {1'b1, 32'h0});
    step();
    @(negedge clock);
    check("bp_second_out", {rsp_o_valid, rsp_o_pc}, {1'b1, 32'h4});
    check("bp_issue_resumes", pc_ready, 1);
    step();
    drain();

    // Flush with two in flight and no responses yet.
    mem_hold = 1'b1;
    drive_pc(32'h40);
    @(negedge clock);
    check("fl1_acc0", pc_ready, 1);
    step();
    drive_pc(32'h44);
    @(negedge clock);
    check("fl1_acc1", pc_ready, 1);
    step();
    flush = 1'b1;
    drive_pc(32'h100);
    @(negedge clock);
    check("fl1_gated", {pc_ready, mem_req_valid, rsp_o_valid}, 3'b000);
    step();
    flush    = 1'b0;
    mem_hold = 1'b0;
    s = out_cnt;
    @(negedge clock);
    check("fl1_drop", dut.drop_q, 2);
    check("fl1_accept_after", pc_ready, 1);
    step();
    drain();
    check("fl1_outs", out_cnt - s, 1);
    check("fl1_drop_done", dut.drop_q, 0);

    // Flush coincident with a response, two outstanding.
    mem_hold = 1'b1;
    drive_pc(32'h200);
    @(negedge clock);
    check("fl2_acc0", pc_ready, 1);
    step();
    drive_pc(32'h204);
    @(negedge clock);
    check("fl2_acc1", pc_ready, 1);
    step();
    pc_valid = 1'b0;
    flush    = 1'b1;
    mem_hold = 1'b0;
    @(negedge clock);
    check("fl2_rsp_in_flush", {mem_rsp_valid, rsp_o_valid}, 2'b10);
    step();
    flush = 1'b0;
    s = out_cnt;
    drive_pc(32'h300);
    @(negedge clock);
    check("fl2_drop", dut.drop_q, 1);
    step();
    drain();
    check("fl2_outs", out_cnt - s, 1);

    // Asynchronous reset mid-stream.
    rsp_o_ready = 1'b0;
    drive_pc(32'h500);
    step();
    drive_pc(32'h504);
    step();
    pc_valid = 1'b0;
    step();
    step();
    @(negedge clock);
    check("ar_valid_before", rsp_o_valid, 1);
    @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    check("ar_valid_drop", rsp_o_valid, 0);
    check("ar_fields", {rsp_o_pc, rsp_o_index, rsp_o_inst}, 0);
    check("ar_ptrs", {dut.wp_q, dut.fp_q, dut.rp_q, dut.drop_q}, 0);
    step();
    step();
    reset = 1'b1;
    rsp_o_ready = 1'b1;
    s = out_cnt;
    drive_pc(32'h600);
    step();
    drain();
    check("ar_recover_outs", out_cnt - s, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
